// File: rtl/ssd_pkg.sv
// Shared types and the seven-segment encoder for the keypad entry display.
`timescale 1ns/1ps
package ssd_pkg;

    // Number of digits entered so far. The encoding is also the digit count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } entry_state_t;

    // Pattern for a digit that has not been filled in yet.
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Hex value to {a,b,c,d,e,f,g}. Segments are active-high.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        logic [6:0] seg;
        case (hex)
            4'h0: seg = 7'b1111110;
            4'h1: seg = 7'b0110000;
            4'h2: seg = 7'b1101101;
            4'h3: seg = 7'b1111001;
            4'h4: seg = 7'b0110011;
            4'h5: seg = 7'b1011011;
            4'h6: seg = 7'b1011111;
            4'h7: seg = 7'b1110000;
            4'h8: seg = 7'b1111111;
            4'h9: seg = 7'b1111011;
            4'hA: seg = 7'b1110111;
            4'hB: seg = 7'b0011111;
            4'hC: seg = 7'b1001110;
            4'hD: seg = 7'b0111101;
            4'hE: seg = 7'b1001111;
            4'hF: seg = 7'b1000111;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/ssd_refresh_tick.sv
// Free-running divider that pulses tick for one cycle every CLK_FREQ/REFRESH_HZ cycles.
`timescale 1ns/1ps
module ssd_refresh_tick #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int REFRESH_HZ = 1_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int DIV = CLK_FREQ / REFRESH_HZ;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == LAST);

    // Count 0..DIV-1 and wrap on the tick cycle.
    always_comb begin
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    // Divider register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ssd_entry_mux.sv
// Two-digit key entry buffer driving a PmodSSD. Mode 0 shows the most recent digit
// on a button-selected side. Mode 1 multiplexes both digits at the refresh rate.
`timescale 1ns/1ps
module ssd_entry_mux
    import ssd_pkg::*;
#(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int REFRESH_HZ  = 1_000,
    parameter bit BLANK_EMPTY = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       clear,
    input  logic       mode,
    input  logic       sel_toggle,
    output logic [6:0] seg,
    output logic       chip_sel,
    output logic [3:0] left_digit,
    output logic [3:0] right_digit,
    output logic [1:0] digit_count
);

    localparam int DIV = CLK_FREQ / REFRESH_HZ;
    localparam logic [6:0] UNFILLED_SEG = BLANK_EMPTY ? SEG_BLANK : hex_to_seg(4'h0);

    if (DIV < 2) begin : g_div_check
        $error("ssd_entry_mux: CLK_FREQ/REFRESH_HZ must be at least 2");
    end

    entry_state_t state_q, state_d;
    logic [3:0]   left_q, left_d;
    logic [3:0]   right_q, right_d;
    logic         chip_sel_q, chip_sel_d;
    logic [6:0]   seg_q, seg_d;
    logic         tick;
    logic         left_filled, right_filled;

    ssd_refresh_tick #(
        .CLK_FREQ   (CLK_FREQ),
        .REFRESH_HZ (REFRESH_HZ)
    ) u_refresh (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // Entry FSM: clear empties the buffer, then a key in the same cycle loads the left digit.
    // NOTE: every output of a combinational block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        left_d  = left_q;
        right_d = right_q;
        if (clear) begin
            right_d = '0;
            if (key_valid) begin
                state_d = ONE;
                left_d  = key_code;
            end else begin
                state_d = EMPTY;
                left_d  = '0;
            end
        end else if (key_valid) begin
            case (state_q)
                EMPTY: begin
                    left_d  = key_code;
                    state_d = ONE;
                end
                ONE: begin
                    right_d = key_code;
                    state_d = TWO;
                end
                TWO: begin
                    left_d  = right_q;
                    right_d = key_code;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // Digit select: button pulses in mode 0, refresh ticks in mode 1; value held across mode changes.
    always_comb begin
        chip_sel_d = chip_sel_q;
        if (mode) begin
            if (tick) chip_sel_d = ~chip_sel_q;
        end else if (sel_toggle) begin
            chip_sel_d = ~chip_sel_q;
        end
    end

    assign left_filled  = (state_q != EMPTY);
    assign right_filled = (state_q == TWO);

    // Segment pattern from the current digit registers, aligned with the next chip_sel.
    always_comb begin
        seg_d = UNFILLED_SEG;
        if (!mode) begin
            if (state_q == ONE)      seg_d = hex_to_seg(left_q);
            else if (state_q == TWO) seg_d = hex_to_seg(right_q);
        end else if (chip_sel_d) begin
            if (left_filled) seg_d = hex_to_seg(left_q);
        end else if (right_filled) begin
            seg_d = hex_to_seg(right_q);
        end
    end

    // Entry, select and segment registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            left_q     <= '0;
            right_q    <= '0;
            chip_sel_q <= 1'b0;
            seg_q      <= SEG_BLANK;
        end else begin
            state_q    <= state_d;
            left_q     <= left_d;
            right_q    <= right_d;
            chip_sel_q <= chip_sel_d;
            seg_q      <= seg_d;
        end
    end

    assign seg         = seg_q;
    assign chip_sel    = chip_sel_q;
    assign left_digit  = left_q;
    assign right_digit = right_q;
    assign digit_count = state_q;

endmodule
